// File: rtl/morse_pkg.sv
// Shared encodings for the morse spy game: FSM states, symbol codes and
// the default dot/dash threshold.
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REC    = 2'd1,
        ST_CHECK  = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SYM_NONE = 2'b00,
        SYM_DOT  = 2'b01,
        SYM_DASH = 2'b10,
        SYM_SEP  = 2'b11
    } sym_t;

    localparam int DASH_TICKS_DEF = 3;

endpackage

// File: rtl/morse_key_event.sv
// Brings one active-low push key into the clock domain and turns its
// synchronised edges into single-cycle press/release pulses.
module morse_key_event (
    input  logic clock,
    input  logic resetn,
    input  logic key_n,
    output logic press_p,
    output logic release_p
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // The key is active-low, so a press is a falling synchronised edge.
    assign press_p   = prev & ~sync2;
    assign release_p = ~prev & sync2;

endmodule

// File: rtl/morse_round_ctrl.sv
// Multi-round record/check sequencer: records player 1's morse symbols,
// checks player 2's symbols against them and keeps the score.
module morse_round_ctrl
    import morse_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int DASH_TICKS = DASH_TICKS_DEF,
    parameter int ROUNDS     = 4,
    parameter int SCORE_W    = 4
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               tick,
    input  logic               user_n,
    input  logic               next_n,
    input  logic               done_n,
    output logic [1:0]         state,
    output logic [ADDR_W:0]    rec_len,
    output logic [ADDR_W-1:0]  ptr,
    output logic [1:0]         exp_sym,
    output logic [1:0]         last_sym,
    output logic               match_p,
    output logic               miss_p,
    output logic               overflow,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] round,
    output logic               game_over
);

    localparam int                 HELD_W   = $clog2(DASH_TICKS + 1);
    localparam logic [HELD_W-1:0]  HELD_MAX = HELD_W'(DASH_TICKS);
    localparam logic [ADDR_W:0]    LEN_MAX  = (ADDR_W + 1)'(DEPTH);
    localparam logic [SCORE_W-1:0] ROUND_END = SCORE_W'(ROUNDS);

    logic user_press;
    logic user_release;
    logic next_press;
    logic next_release_unused;
    logic done_press;
    logic done_release_unused;

    morse_key_event u_user_key (
        .clock     (clock),
        .resetn    (resetn),
        .key_n     (user_n),
        .press_p   (user_press),
        .release_p (user_release)
    );

    morse_key_event u_next_key (
        .clock     (clock),
        .resetn    (resetn),
        .key_n     (next_n),
        .press_p   (next_press),
        .release_p (next_release_unused)
    );

    morse_key_event u_done_key (
        .clock     (clock),
        .resetn    (resetn),
        .key_n     (done_n),
        .press_p   (done_press),
        .release_p (done_release_unused)
    );

    state_t             state_q;
    state_t             state_d;
    logic               armed;
    logic [HELD_W-1:0]  held;
    sym_t               sym_buf [DEPTH];
    sym_t               sym;
    logic               sym_valid;
    sym_t               buf_sym;
    logic               ptr_last;
    logic [SCORE_W-1:0] round_next;

    logic rec_clear;
    logic rec_write;
    logic ovf_set;
    logic ptr_clear;
    logic ptr_inc;
    logic score_inc;
    logic round_inc;
    logic go_set;

    // SEP takes priority over a simultaneous user release; that release is lost.
    assign sym_valid = next_press | (user_release & armed);
    assign sym       = next_press          ? SYM_SEP  :
                       (held >= HELD_MAX)  ? SYM_DASH : SYM_DOT;

    assign buf_sym    = sym_buf[ptr];
    assign ptr_last   = (({1'b0, ptr} + (ADDR_W + 1)'(1)) == rec_len);
    assign round_next = round + SCORE_W'(1);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rec_clear = 1'b0;
        rec_write = 1'b0;
        ovf_set   = 1'b0;
        ptr_clear = 1'b0;
        ptr_inc   = 1'b0;
        score_inc = 1'b0;
        round_inc = 1'b0;
        go_set    = 1'b0;
        match_p   = 1'b0;
        miss_p    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (done_press) begin
                    state_d   = ST_REC;
                    rec_clear = 1'b1;
                end
            end
            ST_REC: begin
                if (done_press) begin
                    if (rec_len != '0) begin
                        state_d   = ST_CHECK;
                        ptr_clear = 1'b1;
                    end
                end else if (sym_valid) begin
                    if (rec_len < LEN_MAX) begin
                        rec_write = 1'b1;
                    end else begin
                        ovf_set = 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                if (done_press) begin
                    state_d = ST_RESULT;
                end else if (sym_valid) begin
                    if (sym == buf_sym) begin
                        match_p = 1'b1;
                        // The final match ends the round and leaves ptr in range.
                        if (ptr_last) begin
                            score_inc = 1'b1;
                            state_d   = ST_RESULT;
                        end else begin
                            ptr_inc = 1'b1;
                        end
                    end else begin
                        miss_p = 1'b1;
                    end
                end
            end
            ST_RESULT: begin
                if (done_press && !game_over) begin
                    round_inc = 1'b1;
                    if (round_next == ROUND_END) begin
                        go_set = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Any state change disarms the key so a press spanning it yields nothing.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            armed <= 1'b0;
            held  <= '0;
        end else if (state_d != state_q) begin
            armed <= 1'b0;
        end else if (user_press) begin
            armed <= 1'b1;
            held  <= '0;
        end else if (user_release) begin
            armed <= 1'b0;
        end else if (armed && tick && (held < HELD_MAX)) begin
            held <= held + HELD_W'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rec_len   <= '0;
            ptr       <= '0;
            last_sym  <= '0;
            overflow  <= 1'b0;
            score     <= '0;
            round     <= '0;
            game_over <= 1'b0;
        end else begin
            if (rec_clear) begin
                rec_len  <= '0;
                ptr      <= '0;
                overflow <= 1'b0;
            end
            if (rec_write) begin
                rec_len <= rec_len + (ADDR_W + 1)'(1);
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end
            if (ptr_clear) begin
                ptr <= '0;
            end else if (ptr_inc) begin
                ptr <= ptr + ADDR_W'(1);
            end
            if (score_inc && (score != '1)) begin
                score <= score + SCORE_W'(1);
            end
            if (round_inc) begin
                round <= round_next;
            end
            if (go_set) begin
                game_over <= 1'b1;
            end
            if (sym_valid && !done_press && !game_over) begin
                last_sym <= sym;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rec_write) begin
            sym_buf[rec_len[ADDR_W-1:0]] <= sym;
        end
    end

    assign state   = state_q;
    assign exp_sym = (state_q == ST_CHECK) ? buf_sym : SYM_NONE;

endmodule

// File: doc/morse_round_ctrl.md
Name: morse_round_ctrl

Overview:
- Parametrised game sequencer for the morse-code spy game: a multi-round record/check controller.
- In each round it records the morse sequence that player 1 keys in, then checks player 2's keyed sequence against it symbol by symbol.
- It keeps a score across ROUNDS rounds. The symbol buffer is internal; VGA/HEX/LED logic consumes its registered status outputs.
- Replaces ad-hoc gated clocks with a single clock plus a tick enable.

Parameters:
- DEPTH, 16: symbol slots in the buffer (power of two, ≥2).
- ADDR_W, 4: log2(DEPTH).
- DASH_TICKS, 3: key-held ticks at or above which a press is a dash.
- ROUNDS, 4: rounds per game (≥1).
- SCORE_W, 4: score/round counter width.

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- resetn  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle enable at game rate (1 Hz from rate_divider).
- user_n  in  1  morse key, active-low, asynchronous.
- next_n  in  1  letter-separator key, active-low, asynchronous.
- done_n  in  1  phase-done key, active-low, asynchronous.
- state  out  2  0=IDLE, 1=REC, 2=CHECK, 3=RESULT.
- rec_len  out  ADDR_W+1  symbols recorded this round.
- ptr  out  ADDR_W  check pointer into the buffer.
- exp_sym  out  2  buf[ptr]; 00 when not in CHECK.
- last_sym  out  2  last classified symbol.
- match_p  out  1  one-cycle pulse: checked symbol matched.
- miss_p  out  1  one-cycle pulse: checked symbol mismatched.
- overflow  out  1  sticky per round: a symbol was dropped because the buffer was full.
- score  out  SCORE_W  rounds completed correctly.
- round  out  SCORE_W  current round index, 0-based.
- game_over  out  1  all rounds finished.

Behaviour:

Reset:
- All outputs and internal registers are 0 and state is IDLE.
- Buffer contents are don't-care.

Key handling:
- Each key passes through a 2-FF synchroniser and then an edge detector.
- Press = synchronised 1→0; release = 0→1.
- An event acts on the registers on the clock edge after it is detected, i.e. 3 clocks after the pin change.

Symbol classification (user_n):
- On press: held-counter cleared; armed=1.
- While held: held-counter +1 on each tick, saturating at DASH_TICKS.
- On release with armed=1: symbol = DASH (10) if held ≥ DASH_TICKS, else DOT (01). This includes held=0.
- A next_n press yields SEP (11).
- last_sym updates on every symbol produced.
- Any state change clears armed, so a press spanning a transition produces nothing.

Simultaneous events:
- A done press in the same cycle as a symbol drops the symbol; done wins.
- A SEP in the same cycle as a key release: SEP is processed first, and the user symbol is dropped.

State transitions:
- IDLE:
  - done → REC; rec_len=0, overflow=0.
- REC:
  - Each symbol: if rec_len<DEPTH, buf[rec_len]=sym and rec_len+1; else dropped and overflow=1.
  - done with rec_len=0 → ignored, stay in REC.
  - done with rec_len>0 → CHECK; ptr=0.
- CHECK:
  - Each symbol is compared with buf[ptr].
  - Equal → match_p, ptr+1. Unequal → miss_p, ptr unchanged (retry).
  - When a match makes ptr+1 == rec_len → score+1 (saturating at all-ones) and → RESULT on the same edge; match_p still pulses.
  - done → RESULT with no score (give up).
- RESULT:
  - done → round+1.
  - If the new round == ROUNDS: game_over=1 and stay in RESULT; all events are ignored until resetn.
  - Otherwise → IDLE.

Other rules:
- rec_len == DEPTH is legal; ptr wraps never occur because the compare terminates at rec_len.
- match_p and miss_p are never both high and never high outside CHECK.
- Asserting resetn mid-round aborts immediately to reset values.

Decomposition:
- Package morse_pkg: state codes, symbol codes (SYM_NONE=00, DOT=01, DASH=10, SEP=11), default DASH_TICKS.
- Sub-module morse_key_event: 2-FF synchroniser plus press/release pulse outputs; instanced three times.
- The classifier, buffer (register array, DEPTH×2) and FSM live in morse_round_ctrl.

Test Plan:
1. Reset, then done → state 1. Hold user for 1 tick, release; hold user for 4 ticks, release; press next; press done → rec_len=3, buf=01,10,11, state=2.
2. In CHECK, key DOT, DASH, SEP → three match_p pulses, ptr 0→1→2, state=3, score=1 on the edge of the third match.
3. In CHECK with buf=01: key DASH → miss_p, ptr=0; then DOT → match_p, state=3, score=1.
4. DEPTH=16: record 17 DOTs → rec_len=16, overflow=1. Done in CHECK after 5 matches → state=3, score unchanged.
5. ROUNDS=2: complete two rounds and press done in RESULT each time → round=2, game_over=1, state stays 3. A further done press has no effect. Pulsing resetn → all outputs 0.
6. Edge cases, each with its own stimulus:
   - Release user in the same cycle as the done press (in REC) → symbol dropped, rec_len unchanged, state=2.
   - Hold user across the IDLE→REC transition → no symbol on release.
   - Done with rec_len=0 → state stays 1.
